// File: rtl/fp_stack_pkg.sv
// Shared definitions for the floating-point operand stack: default sizes
// and the per-cycle operation decode derived from push/pop/empty/full.
package fp_stack_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int DEPTH_DEF      = 8;

    typedef enum logic [1:0] {
        OP_NONE    = 2'd0,
        OP_PUSH    = 2'd1,
        OP_POP     = 2'd2,
        OP_REPLACE = 2'd3
    } stack_op_t;

    // Push and pop together always replace (or bypass when empty).
    // A lone push is only accepted when not full, and a lone pop only when not empty.
    function automatic stack_op_t decode_op(input logic push,
                                            input logic pop,
                                            input logic empty,
                                            input logic full);
        stack_op_t op;
        op = OP_NONE;
        if (push && pop) begin
            op = OP_REPLACE;
        end else if (push && !full) begin
            op = OP_PUSH;
        end else if (pop && !empty) begin
            op = OP_POP;
        end
        return op;
    endfunction

endpackage

// File: rtl/fp_stack_ptr.sv
// Up/down occupancy counter for the operand stack. Saturates at 0 and DEPTH;
// up and down together hold the count. full/empty are decoded from the count.
module fp_stack_ptr #(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   up,
    input  logic                   down,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0] count_p1;

    // Occupancy register: step up or down, never past the ends.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_p1 <= '0;
        end else if (up && !down && (count_p1 != CW'(DEPTH))) begin
            count_p1 <= count_p1 + CW'(1);
        end else if (down && !up && (count_p1 != '0)) begin
            count_p1 <= count_p1 - CW'(1);
        end
    end

    assign count = count_p1;
    assign full  = (count_p1 == CW'(DEPTH));
    assign empty = (count_p1 == '0);

endmodule

// File: rtl/fp_operand_stack.sv
// LIFO operand stack for the floating-point co-processor datapath.
// Popped words are returned registered one cycle after the request;
// top_data is a combinational peek of the current top entry.
// Optional sticky overflow/underflow flags with err_clr are built when the
// macro FP_STACK_ERR_FLAGS_EN is defined.
module fp_operand_stack
    import fp_stack_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [DATA_WIDTH-1:0]  push_data,
    output logic [DATA_WIDTH-1:0]  pop_data,
    output logic                   pop_valid,
    output logic [DATA_WIDTH-1:0]  top_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
`ifdef FP_STACK_ERR_FLAGS_EN
    ,
    input  logic                   err_clr,
    output logic                   overflow_err,
    output logic                   underflow_err
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    stack_op_t             op_p0;
    logic [AW-1:0]         wr_idx_p0;
    logic [AW-1:0]         top_idx_p0;
    logic [DATA_WIDTH-1:0] pop_data_p1;
    logic                  vld_p1;

    assign op_p0      = decode_op(push, pop, empty, full);
    // While not full, count itself addresses the next free slot.
    assign wr_idx_p0  = AW'(count);
    assign top_idx_p0 = AW'(count - CW'(1));

    fp_stack_ptr #(
        .DEPTH (DEPTH)
    ) u_ptr (
        .clk   (clk),
        .n_rst (n_rst),
        .up    (op_p0 == OP_PUSH),
        .down  (op_p0 == OP_POP),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // Storage writes: push fills the next slot, replace overwrites the top.
    always_ff @(posedge clk) begin
        if (op_p0 == OP_PUSH) begin
            mem[wr_idx_p0] <= push_data;
        end else if ((op_p0 == OP_REPLACE) && !empty) begin
            mem[top_idx_p0] <= push_data;
        end
    end

    // ---- stage p0 -> p1: registered pop result ----
    // Pop result register; an empty replace forwards push_data straight through.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pop_data_p1 <= '0;
            vld_p1      <= 1'b0;
        end else begin
            vld_p1 <= 1'b0;
            case (op_p0)
                OP_POP: begin
                    pop_data_p1 <= mem[top_idx_p0];
                    vld_p1      <= 1'b1;
                end
                OP_REPLACE: begin
                    pop_data_p1 <= empty ? push_data : mem[top_idx_p0];
                    vld_p1      <= 1'b1;
                end
                default: begin
                    pop_data_p1 <= pop_data_p1;
                end
            endcase
        end
    end

    assign pop_data  = pop_data_p1;
    assign pop_valid = vld_p1;
    assign top_data  = empty ? '0 : mem[top_idx_p0];

`ifdef FP_STACK_ERR_FLAGS_EN
    logic overflow_ev;
    logic underflow_ev;

    assign overflow_ev  = push && !pop && full;
    assign underflow_ev = pop && !push && empty;

    // Sticky error flags; a new event in the clear cycle keeps the flag set.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            if (overflow_ev) begin
                overflow_err <= 1'b1;
            end else if (err_clr) begin
                overflow_err <= 1'b0;
            end
            if (underflow_ev) begin
                underflow_err <= 1'b1;
            end else if (err_clr) begin
                underflow_err <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fp_operand_stack.sv
// Directed bench for fp_operand_stack: a queue-based LIFO model is checked
// against the DUT every falling edge, plus literal expectations per scenario.
// Build with FP_STACK_ERR_FLAGS_EN defined to cover the error flags.
module tb_fp_operand_stack;

    localparam int DW = 32;
    localparam int DP = 8;

    logic          tb_clk;
    logic          n_rst;
    logic          push;
    logic          pop;
    logic [DW-1:0] push_data;
    logic [DW-1:0] pop_data;
    logic          pop_valid;
    logic [DW-1:0] top_data;
    logic [3:0]    count;
    logic          full;
    logic          empty;
    logic          err_clr;
`ifdef FP_STACK_ERR_FLAGS_EN
    logic          overflow_err;
    logic          underflow_err;
`endif

    fp_operand_stack #(
        .DATA_WIDTH (DW),
        .DEPTH      (DP)
    ) dut (
        .clk       (tb_clk),
        .n_rst     (n_rst),
        .push      (push),
        .pop       (pop),
        .push_data (push_data),
        .pop_data  (pop_data),
        .pop_valid (pop_valid),
        .top_data  (top_data),
        .count     (count),
        .full      (full),
        .empty     (empty)
`ifdef FP_STACK_ERR_FLAGS_EN
        ,
        .err_clr       (err_clr),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
`endif
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    int vectors = 0;
    int errors  = 0;
    bit chk_en  = 0;

    // Behavioural model
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_pd;
    logic          m_vld;
    logic          m_ovf;
    logic          m_unf;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pd  = '0;
        m_vld = 1'b0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_step(input logic p, input logic q, input logic [DW-1:0] d, input logic clr);
        bit ov;
        bit un;
        ov    = 0;
        un    = 0;
        m_vld = 1'b0;
        if (p && q) begin
            m_vld = 1'b1;
            if (mq.size() == 0) begin
                m_pd = d;
            end else begin
                m_pd = mq[mq.size()-1];
                mq[mq.size()-1] = d;
            end
        end else if (p) begin
            if (mq.size() < DP) mq.push_back(d);
            else ov = 1;
        end else if (q) begin
            if (mq.size() > 0) begin
                m_pd  = mq.pop_back();
                m_vld = 1'b1;
            end else begin
                un = 1;
            end
        end
        m_ovf = ov ? 1'b1 : (clr ? 1'b0 : m_ovf);
        m_unf = un ? 1'b1 : (clr ? 1'b0 : m_unf);
    endtask

    // One request cycle: drive, let the edge sample it, advance the model.
    task automatic step(input logic p, input logic q, input logic [DW-1:0] d, input logic clr = 1'b0);
        push      = p;
        pop       = q;
        push_data = d;
        err_clr   = clr;
        @(posedge tb_clk);
        model_step(p, q, d, clr);
        #1;
        push    = 1'b0;
        pop     = 1'b0;
        err_clr = 1'b0;
    endtask

    // Compare process: every falling edge, DUT versus model.
    always @(negedge tb_clk) begin
        if (chk_en) begin
            check("count",     DW'(count),     DW'(mq.size()));
            check("empty",     DW'(empty),     DW'(mq.size() == 0));
            check("full",      DW'(full),      DW'(mq.size() == DP));
            check("top_data",  top_data,       (mq.size() == 0) ? '0 : mq[mq.size()-1]);
            check("pop_valid", DW'(pop_valid), DW'(m_vld));
            check("pop_data",  pop_data,       m_pd);
`ifdef FP_STACK_ERR_FLAGS_EN
            check("overflow_err",  DW'(overflow_err),  DW'(m_ovf));
            check("underflow_err", DW'(underflow_err), DW'(m_unf));
`endif
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    logic [DW-1:0] seq [3];

    initial begin
        n_rst     = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        push_data = '0;
        err_clr   = 1'b0;
        model_reset();
        chk_en    = 1;
        #12;
        n_rst = 1'b1;
        @(posedge tb_clk);
        #1;

        // Reset then idle 3 cycles
        repeat (3) step(0, 0, '0);
        check("rst count",     DW'(count),     0);
        check("rst empty",     DW'(empty),     1);
        check("rst full",      DW'(full),      0);
        check("rst pop_valid", DW'(pop_valid), 0);
        check("rst pop_data",  pop_data,       0);

        // Push three, pop three in LIFO order
        step(1, 0, 32'h3F800000);
        step(1, 0, 32'h40000000);
        step(1, 0, 32'h40400000);
        check("lifo count3", DW'(count), 3);
        seq[0] = 32'h40400000;
        seq[1] = 32'h40000000;
        seq[2] = 32'h3F800000;
        for (int i = 0; i < 3; i++) begin
            step(0, 1, '0);
            check("lifo pop_data",  pop_data,       seq[i]);
            check("lifo pop_valid", DW'(pop_valid), 1);
            check("lifo count",     DW'(count),     DW'(2 - i));
        end
        step(0, 0, '0);
        check("lifo valid drop", DW'(pop_valid), 0);

        // Fill, then push once more when full
        for (int i = 1; i <= 8; i++) step(1, 0, DW'(i));
        step(1, 0, 32'h9);
        check("ovf full",     DW'(full),  1);
        check("ovf count",    DW'(count), 8);
        check("ovf top_data", top_data,   32'h8);
`ifdef FP_STACK_ERR_FLAGS_EN
        check("ovf flag", DW'(overflow_err), 1);
`endif

        // Replace while full: no overflow event, count holds
        step(1, 1, 32'h77);
        check("full repl pop_data", pop_data,   32'h8);
        check("full repl count",    DW'(count), 8);
        check("full repl top",      top_data,   32'h77);
        step(0, 0, '0, 1'b1);

        // Drain and pop on empty
        repeat (8) step(0, 1, '0);
        check("drain last", pop_data, 32'h1);
        step(0, 1, '0);
        check("unf pop_valid", DW'(pop_valid), 0);
        check("unf count",     DW'(count),     0);
        check("unf pop_data",  pop_data,       32'h1);
`ifdef FP_STACK_ERR_FLAGS_EN
        check("unf flag", DW'(underflow_err), 1);
        step(0, 1, '0, 1'b1);
        check("unf clr+event", DW'(underflow_err), 1);
        step(0, 0, '0, 1'b1);
        check("unf cleared", DW'(underflow_err), 0);
        check("ovf cleared", DW'(overflow_err),  0);
`endif

        // Replace with count 2, then bypass when empty
        step(1, 0, 32'h9);
        step(1, 0, 32'hA);
        step(1, 1, 32'hB);
        check("repl pop_data",  pop_data,       32'hA);
        check("repl pop_valid", DW'(pop_valid), 1);
        check("repl count",     DW'(count),     2);
        check("repl top_data",  top_data,       32'hB);
        step(0, 1, '0);
        check("repl popped B", pop_data, 32'hB);
        step(0, 1, '0);
        check("repl popped 9", pop_data, 32'h9);
        step(1, 1, 32'hC);
        check("bypass pop_data",  pop_data,       32'hC);
        check("bypass pop_valid", DW'(pop_valid), 1);
        check("bypass count",     DW'(count),     0);
        check("bypass top_data",  top_data,       0);

        // Async reset in the middle of a cycle
        repeat (4) step(1, 0, 32'h5);
        check("pre-rst count", DW'(count), 4);
        #2;
        n_rst = 1'b0;
        #1;
        check("async rst count", DW'(count), 0);
        check("async rst empty", DW'(empty), 1);
        check("async rst full",  DW'(full),  0);
        check("async rst pd",    pop_data,   0);
        model_reset();
        @(posedge tb_clk);
        #2;
        n_rst = 1'b1;
        step(1, 0, 32'hDEAD);
        check("post-rst count", DW'(count), 1);
        check("post-rst top",   top_data,   32'hDEAD);
        step(0, 1, '0);
        check("post-rst pop", pop_data, 32'hDEAD);
        step(0, 0, '0);

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
